// File: rtl/weight_pkg.sv
// Shared types and default dimensions for the systolic array weight-load path.
//   state_t : buffer sequencing states (FILL -> TRIGGER -> STREAM -> FILL)
//   DATA_W  : bits per weight element
//   ROWS    : rows in a weight tile (array height)
//   COLS    : elements per row (array width)
package weight_pkg;

  localparam int DATA_W = 8;
  localparam int ROWS   = 4;
  localparam int COLS   = 4;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    TRIGGER = 2'd1,
    STREAM  = 2'd2
  } state_t;

endpackage

// File: rtl/weight_buffer_if.sv
// Bundle between the host-side producer / weight counter and weight_buffer.
//   in_valid, in_data, in_ready : element handshake from the host/AHB side
//   trigger_weight              : one-cycle "tile complete" pulse to the weight counter
//   load, systolic_done         : weight counter controls during streaming
//   weight_row                  : packed row to the array, column 0 in the LSBs
//   busy                        : buffer is not accepting a new tile
// master = producer/counter side, slave = the buffer.
interface weight_buffer_if
  import weight_pkg::*;
#(
  parameter int DATA_W = weight_pkg::DATA_W,
  parameter int COLS   = weight_pkg::COLS
);

  logic                   in_valid;
  logic [DATA_W-1:0]      in_data;
  logic                   in_ready;
  logic                   trigger_weight;
  logic                   load;
  logic                   systolic_done;
  logic [COLS*DATA_W-1:0] weight_row;
  logic                   busy;

  modport master (
    output in_valid, in_data, load, systolic_done,
    input  in_ready, trigger_weight, weight_row, busy
  );

  modport slave (
    input  in_valid, in_data, load, systolic_done,
    output in_ready, trigger_weight, weight_row, busy
  );

endinterface

// File: rtl/flex_counter.sv
// Generic up-counter with synchronous clear and programmable wrap value.
//   clk, n_rst   : clock, asynchronous active-low reset
//   clear        : synchronous clear to zero (wins over count_enable)
//   count_enable : advance by one this cycle
//   rollover_val : last value before wrapping back to zero
//   count_out    : current count
module flex_counter #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            clear,
  input  logic            count_enable,
  input  logic [SIZE-1:0] rollover_val,
  output logic [SIZE-1:0] count_out
);

  logic [SIZE-1:0] count_q, count_d;

  // NOTE: combinational blocks assign a default first so no path leaves a latch.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      count_d = (count_q == rollover_val) ? '0 : count_q + SIZE'(1);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_out = count_q;

endmodule

// File: rtl/weight_buffer.sv
// Weight tile buffer feeding the systolic array weight shift chain.
// Collects ROWS*COLS elements (element k -> row k/COLS, col k%COLS), pulses
// trigger_weight once the tile is full, then presents one row per load cycle,
// bottom row first, padding with zeros once all rows have gone out. The tile
// is cleared and filling resumes only on systolic_done.
//   clk, n_rst : clock, asynchronous active-low reset
//   bus        : weight_buffer_if slave modport (handshake, counter controls, row out)
// ROWS and COLS must each be at least 2.
module weight_buffer
  import weight_pkg::*;
#(
  parameter int DATA_W = weight_pkg::DATA_W,
  parameter int ROWS   = weight_pkg::ROWS,
  parameter int COLS   = weight_pkg::COLS
) (
  input logic            clk,
  input logic            n_rst,
  weight_buffer_if.slave bus
);

  localparam int N      = ROWS * COLS;
  localparam int CNT_W  = $clog2(N);
  localparam int RIDX_W = $clog2(ROWS);
  localparam int CIDX_W = $clog2(COLS);
  localparam int RD_W   = $clog2(ROWS + 1);

  typedef logic [ROWS-1:0][COLS-1:0][DATA_W-1:0] tile_t;

  state_t          state_q, state_d;
  tile_t           buf_q, buf_d;
  logic [RD_W-1:0] rd_idx_q, rd_idx_d;
  logic            in_ready_q, in_ready_d;
  logic            trigger_q, trigger_d;
  logic            busy_q, busy_d;

  logic [CNT_W-1:0]  wr_idx;
  logic [RIDX_W-1:0] wr_row, rd_row;
  logic [CIDX_W-1:0] wr_col;
  logic              transfer, fill_done, row_valid;

  // in_ready_q is high exactly in FILL, so it doubles as the state qualifier.
  assign transfer  = bus.in_valid && in_ready_q;
  assign fill_done = transfer && (wr_idx == CNT_W'(N - 1));

  flex_counter #(.SIZE(CNT_W)) u_wr_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (fill_done),
    .count_enable (transfer),
    .rollover_val (CNT_W'(N - 1)),
    .count_out    (wr_idx)
  );

  assign wr_row = RIDX_W'(wr_idx / CNT_W'(COLS));
  assign wr_col = CIDX_W'(wr_idx % CNT_W'(COLS));

  // Bottom row goes into the shift chain first; once rd_idx saturates at ROWS
  // the output is forced to zero to flush the chain.
  assign row_valid = (state_q == STREAM) && bus.load && (rd_idx_q < RD_W'(ROWS));
  assign rd_row    = RIDX_W'(ROWS - 1) - RIDX_W'(rd_idx_q);

  assign bus.weight_row     = row_valid ? buf_q[rd_row] : '0;
  assign bus.in_ready       = in_ready_q;
  assign bus.trigger_weight = trigger_q;
  assign bus.busy           = busy_q;

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    rd_idx_d = rd_idx_q;
    unique case (state_q)
      FILL: begin
        if (transfer)  buf_d[wr_row][wr_col] = bus.in_data;
        if (fill_done) state_d = TRIGGER;
      end
      TRIGGER: state_d = STREAM;
      STREAM: begin
        if (row_valid) rd_idx_d = rd_idx_q + RD_W'(1);
        // The row for a coincident load is still presented from buf_q this cycle.
        if (bus.systolic_done) begin
          state_d  = FILL;
          rd_idx_d = '0;
          buf_d    = '0;
        end
      end
      default: state_d = FILL;
    endcase
    // Outputs are registered from the next state so they line up with state_q.
    in_ready_d = (state_d == FILL);
    trigger_d  = (state_d == TRIGGER);
    busy_d     = (state_d != FILL);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= FILL;
      // NOTE: the tile storage is reset because a partial tile must never leak into a stream.
      buf_q      <= '0;
      rd_idx_q   <= '0;
      in_ready_q <= 1'b1;
      trigger_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      rd_idx_q   <= rd_idx_d;
      in_ready_q <= in_ready_d;
      trigger_q  <= trigger_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_weight_buffer.sv
// Self-checking bench for weight_buffer (DATA_W=8, ROWS=COLS=4).
// Accepted elements are recorded in a tile model; when a tile completes the
// expected rows (bottom first, then zero padding) are pushed to a scoreboard
// queue and popped as load cycles present weight_row.
module tb_weight_buffer;

  localparam int DATA_W = 8;
  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int N      = ROWS * COLS;
  localparam int ROW_W  = COLS * DATA_W;

  logic clk = 1'b0;
  logic n_rst;

  weight_buffer_if #(.DATA_W(DATA_W), .COLS(COLS)) bus ();

  weight_buffer #(.DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] model [N];
  int                model_k;
  logic [ROW_W-1:0]  exp_q [$];

  task automatic check(input string tag, input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer elements until n are accepted. base < 0 gives random data,
  // otherwise element k of the tile carries base + k.
  task automatic send(input int n, input int base, input bit gaps);
    int sent = 0;
    int cyc  = 0;
    bit v;
    while (sent < n && cyc < 400) begin
      @(negedge clk);
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.in_valid = v;
      bus.in_data  = (base < 0) ? 8'($urandom) : 8'(base + model_k);
      #1;
      if (v && bus.in_ready) begin
        model[model_k] = bus.in_data;
        model_k++;
        sent++;
      end
      cyc++;
    end
    check("send_count", ROW_W'(sent), ROW_W'(n));
  endtask

  // in_valid is left as the caller set it, so a held request is exercised.
  task automatic expect_trigger();
    @(negedge clk); #1;
    check("trig_pulse",   ROW_W'(bus.trigger_weight), 1);
    check("trig_ready",   ROW_W'(bus.in_ready),       0);
    check("trig_busy",    ROW_W'(bus.busy),           1);
    @(negedge clk); #1;
    check("trig_one_cyc", ROW_W'(bus.trigger_weight), 0);
    check("strm_ready",   ROW_W'(bus.in_ready),       0);
    check("strm_busy",    ROW_W'(bus.busy),           1);
  endtask

  task automatic push_rows(input int n_zero);
    logic [ROW_W-1:0] row;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) row[c*DATA_W +: DATA_W] = model[(ROWS-1-r)*COLS + c];
      exp_q.push_back(row);
    end
    for (int z = 0; z < n_zero; z++) exp_q.push_back('0);
  endtask

  task automatic stream(input int n_load, input bit done_last);
    bit last;
    for (int i = 0; i < n_load; i++) begin
      last = done_last && (i == n_load - 1);
      @(negedge clk);
      bus.load          = 1'b1;
      bus.systolic_done = last;
      if (last) bus.in_valid = 1'b0;
      #1;
      if (exp_q.size() == 0) check("sb_underflow", 1, 0);
      else                   check("stream_row", bus.weight_row, exp_q.pop_front());
      check("stream_no_accept", ROW_W'(bus.in_ready), 0);
    end
    if (!done_last) begin
      @(negedge clk);
      bus.load          = 1'b0;
      bus.systolic_done = 1'b1;
      bus.in_valid      = 1'b0;
      #1;
      check("done_row_zero", bus.weight_row, 0);
    end
    @(negedge clk);
    bus.load          = 1'b0;
    bus.systolic_done = 1'b0;
    #1;
    check("post_ready", ROW_W'(bus.in_ready), 1);
    check("post_busy",  ROW_W'(bus.busy),     0);
    check("sb_drained", ROW_W'(exp_q.size()), 0);
    model_k = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst             = 1'b0;
    bus.in_valid      = 1'b0;
    bus.in_data       = '0;
    bus.load          = 1'b0;
    bus.systolic_done = 1'b0;
    model_k           = 0;

    // Reset values
    #23;
    check("rst_ready", ROW_W'(bus.in_ready),       1);
    check("rst_trig",  ROW_W'(bus.trigger_weight), 0);
    check("rst_row",   bus.weight_row,             0);
    check("rst_busy",  ROW_W'(bus.busy),           0);
    @(negedge clk);
    n_rst = 1'b1;

    // Back-to-back fill 0x01..0x10, in_valid held through TRIGGER/STREAM,
    // 7 load cycles (3 flush zeros), then a separate systolic_done.
    send(N, 1, 1'b0);
    expect_trigger();
    push_rows(3);
    stream(7, 1'b0);

    // Random data with gaps; systolic_done coincides with the last row.
    send(N, -1, 1'b1);
    expect_trigger();
    push_rows(0);
    stream(ROWS, 1'b1);

    // Reset mid-fill discards the partial tile.
    send(9, 8'h55, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_rst        = 1'b0;
    #1;
    check("midrst_ready", ROW_W'(bus.in_ready), 1);
    check("midrst_busy",  ROW_W'(bus.busy),     0);
    @(negedge clk);
    n_rst   = 1'b1;
    model_k = 0;
    send(N, 8'hA0, 1'b0);
    expect_trigger();
    push_rows(1);
    stream(ROWS + 1, 1'b0);

    // Spurious load/systolic_done during FILL must not disturb the write index.
    send(5, 8'h30, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.in_valid      = 1'b0;
      bus.load          = 1'b1;
      bus.systolic_done = 1'b1;
      #1;
      check("spur_row",   bus.weight_row,             0);
      check("spur_ready", ROW_W'(bus.in_ready),       1);
      check("spur_busy",  ROW_W'(bus.busy),           0);
      check("spur_trig",  ROW_W'(bus.trigger_weight), 0);
    end
    @(negedge clk);
    bus.load          = 1'b0;
    bus.systolic_done = 1'b0;
    send(N - 5, 8'h30, 1'b0);
    expect_trigger();
    push_rows(0);
    stream(ROWS, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/weight_buffer.md
Name: weight_buffer

Overview:
- Upstream feeder for the systolic array weight-load path.
- Collects a full ROWS x COLS weight tile, one element per handshake, from the host/AHB side.
- Fires a single-cycle trigger_weight to the weight counter. While the counter drives load, it streams one packed row per cycle into the array's weight shift chain.
- Refuses new weights until the counter reports systolic_done, so a tile is never overwritten mid-load.

Parameters:
- DATA_W, 8, bits per weight element
- ROWS, 4, rows in the weight tile (array height)
- COLS, 4, elements per row (array width)

Ports:
- clk  in  1  clock
- n_rst  in  1  reset
- in_valid  in  1  upstream element valid
- in_data  in  DATA_W  weight element
- in_ready  out  1  buffer accepts an element this cycle
- trigger_weight  out  1  one-cycle pulse: tile complete, start load
- load  in  1  from weight counter: shift one row this cycle
- systolic_done  in  1  from weight counter: load sequence finished
- weight_row  out  COLS*DATA_W  row presented to the array; column 0 in the LSBs
- busy  out  1  high in any state other than FILL

Interface: reset n_rst, asynchronous, active-low; clock clk.

Behaviour:
- Reset values: state=FILL, write index=0, read index=0, buffer all zeros. Outputs: in_ready=1, trigger_weight=0, weight_row=0, busy=0.
- Storage: ROWS x COLS x DATA_W registers.
  - Element k (0-based arrival order) is stored at row k/COLS, col k%COLS.
- State FILL:
  - in_ready=1.
  - Transfer occurs when in_valid && in_ready. The element is written and the write index is incremented.
  - When the transfer of element ROWS*COLS-1 occurs, go to TRIGGER and clear the write index.
- State TRIGGER:
  - Lasts exactly 1 cycle: in_ready=0, trigger_weight=1, then go to STREAM.
- State STREAM:
  - in_ready=0.
  - weight_row is combinational from the buffer while load=1 and read index < ROWS. Otherwise weight_row=0.
  - Rows are presented bottom-first: read index r selects buffer row ROWS-1-r. r increments on each load=1 cycle and saturates at ROWS.
  - load may stay high longer than ROWS cycles. Surplus cycles present zeros, which flush the chain.
  - On systolic_done=1, go to FILL, clear the read index and clear the buffer.
- Simultaneous events:
  - systolic_done and load in the same cycle: the row is still presented that cycle, then the block returns to FILL.
  - systolic_done outside STREAM is ignored.
  - load outside STREAM is ignored and weight_row stays 0.
- Latency: the last input transfer at cycle t gives trigger_weight at t+1. The weight counter raises load from t+2.
- in_valid while in_ready=0: not a transfer. The producer holds its data; no overrun is possible.
- n_rst asserted mid-fill or mid-stream: returns immediately to the reset values. The partial tile is discarded.
- busy = (state != FILL).

Decomposition:
- Package weight_pkg:
  - state_t enum {FILL=0, TRIGGER=1, STREAM=2}, 2 bits
  - default width constants DATA_W/ROWS/COLS
- Sub-module: reuse flex_counter for the fill write index.
  - Settings: SIZE = $clog2(ROWS*COLS), rollover_val = ROWS*COLS-1, count_enable = transfer, clear = leaving FILL.
  - The TRIGGER transition is decoded from count==ROWS*COLS-1 && transfer.
- The read index is a small local saturating counter.

Test Plan (DATA_W=8, ROWS=COLS=4):
- Reset check: hold n_rst=0 -> in_ready=1, trigger_weight=0, weight_row=0, busy=0.
- Fill and trigger: stream elements 0x01..0x10 back-to-back with in_valid=1 -> in_ready drops the cycle after the 16th transfer, trigger_weight=1 for exactly 1 cycle, busy=1.
- Stream order:
  - Drive load=1 for 7 cycles, then pulse systolic_done.
  - Required weight_row per load cycle: 0x100F0E0D, 0x0C0B0A09, 0x08070605, 0x04030201, then 0, 0, 0.
  - Then in_ready=1 and busy=0.
- Backpressure and gaps: send 16 elements with random in_valid gaps, and hold in_valid=1 during TRIGGER/STREAM -> exactly 16 elements stored, no element accepted while in_ready=0.
- Reset mid-operation: assert n_rst after 9 transfers, then refill with 0xA0..0xAF -> the stream shows rows AF..AC first, with no stale data.
- Spurious inputs: pulse load and systolic_done during FILL -> no state change, weight_row=0, and the write index is preserved (the fill completes after the remaining elements).
